// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address, applies
// relative branches and runs the Start/Done handshake with a cycle counter.
module fetch_unit #(
    parameter int          PW      = 10,
    parameter int          IW      = 9,
    parameter int          OW      = 8,
    parameter logic [IW-1:0] HALT_OP = 9'h1FF,
    parameter int          CW      = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic [IW-1:0] RomData,
    input  logic          BranchRel,
    input  logic          Taken,
    input  logic [OW-1:0] Offset,
    output logic [PW-1:0] RomAddr,
    output logic [IW-1:0] Instr,
    output logic          InstrValid,
    output logic          Done,
    output logic [CW-1:0] Cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_nx;
    logic [CW-1:0] cycles;
    logic [CW-1:0] cycles_nx;
    logic          start_q;
    logic          launch;
    logic          halt;
    logic [PW-1:0] off_ext;

    assign launch  = Start & ~start_q;
    assign halt    = (RomData == HALT_OP);
    assign off_ext = PW'($signed(Offset));

    // start_q keeps tracking Start during reset so a Start held high
    // across reset release is not mistaken for a fresh launch.
    always_ff @(posedge Clk) begin
        start_q <= Start;
        if (!Reset_n) begin
            state  <= IDLE;
            pc     <= '0;
            cycles <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            cycles <= cycles_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        cycles_nx = cycles;
        unique case (state)
            IDLE, DONE: begin
                if (launch) begin
                    state_nx  = RUN;
                    pc_nx     = StartAddr;
                    cycles_nx = '0;
                end
            end
            RUN: begin
                if (launch) begin
                    pc_nx     = StartAddr;
                    cycles_nx = '0;
                end else begin
                    if (cycles != '1) begin
                        cycles_nx = cycles + CW'(1);
                    end
                    if (halt) begin
                        state_nx = DONE;
                    end else if (BranchRel && Taken) begin
                        pc_nx = pc + off_ext;
                    end else begin
                        pc_nx = pc + PW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign RomAddr    = pc;
    assign InstrValid = (state == RUN);
    assign Instr      = (state == RUN) ? RomData : '0;
    assign Done       = (state == DONE);
    assign Cycles     = cycles;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program/branch tables indexed by address, a
// cycle-level reference model and directed programs with literal checks.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] start_addr = '0;
    logic [8:0] rom_data;
    logic       branch_rel;
    logic       taken;
    logic [7:0] offset;
    logic [9:0] rom_addr;
    logic [8:0] instr;
    logic       instr_valid;
    logic       done;
    logic [15:0] cycles;

    logic [8:0] rom [1024];
    logic       br  [1024];
    logic       tk  [1024];
    logic [7:0] off [1024];

    int checks = 0;
    int errors = 0;

    // model: mode 0 idle, 1 running, 2 finished
    int m_mode = 0;
    int m_pc   = 0;
    int m_cyc  = 0;
    bit m_sq   = 1'b0;

    fetch_unit dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Start     (start),
        .StartAddr (start_addr),
        .RomData   (rom_data),
        .BranchRel (branch_rel),
        .Taken     (taken),
        .Offset    (offset),
        .RomAddr   (rom_addr),
        .Instr     (instr),
        .InstrValid(instr_valid),
        .Done      (done),
        .Cycles    (cycles)
    );

    assign rom_data   = rom[rom_addr];
    assign branch_rel = br[rom_addr];
    assign taken      = tk[rom_addr];
    assign offset     = off[rom_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: next PC from the instruction tables at the model PC.
    always @(posedge clk) begin
        bit launch;
        int disp;
        launch = start && !m_sq;
        m_sq   = start;
        if (!rst_n) begin
            m_mode = 0;
            m_pc   = 0;
            m_cyc  = 0;
        end else if (launch) begin
            m_mode = 1;
            m_pc   = int'(start_addr);
            m_cyc  = 0;
        end else if (m_mode == 1) begin
            if (m_cyc < 65535) m_cyc = m_cyc + 1;
            disp = int'($signed(off[m_pc]));
            if (rom[m_pc] == 9'h1FF) m_mode = 2;
            else if (br[m_pc] && tk[m_pc]) m_pc = (m_pc + disp + 1024) % 1024;
            else m_pc = (m_pc + 1) % 1024;
        end
    end

    always @(negedge clk) begin
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("cycles", 32'(cycles), 32'(m_cyc));
        chk("instr", 32'(instr), (m_mode == 1) ? 32'(rom[m_pc]) : 32'd0);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [9:0] a);
        start      = 1'b1;
        start_addr = a;
        step();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] = '0;
            br[i]  = 1'b0;
            tk[i]  = 1'b0;
            off[i] = '0;
        end

        // reset with Start high, then release without a launch
        rst_n = 1'b0;
        start = 1'b1;
        step();
        step();
        chk("t1_addr", 32'(rom_addr), 32'h0);
        chk("t1_done", 32'(done), 32'h0);
        chk("t1_valid", 32'(instr_valid), 32'h0);
        chk("t1_cycles", 32'(cycles), 32'h0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("t1_nolaunch", 32'(instr_valid), 32'h0);
        chk("t1_addr_held", 32'(rom_addr), 32'h0);
        start = 1'b0;
        step();

        // sequential NOPs then halt
        rom[10'h013] = 9'h1FF;
        launch(10'h010);
        chk("t2_a0", 32'(rom_addr), 32'h010);
        chk("t2_v0", 32'(instr_valid), 32'h1);
        step();
        chk("t2_a1", 32'(rom_addr), 32'h011);
        step();
        chk("t2_a2", 32'(rom_addr), 32'h012);
        step();
        chk("t2_a3", 32'(rom_addr), 32'h013);
        chk("t2_halt_instr", 32'(instr), 32'h1FF);
        step();
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_cycles", 32'(cycles), 32'd4);
        chk("t2_valid_off", 32'(instr_valid), 32'h0);

        // taken and not-taken branch at 0x020
        rom[10'h020] = 9'h005;
        br[10'h020]  = 1'b1;
        tk[10'h020]  = 1'b1;
        off[10'h020] = 8'hFB;
        rom[10'h01B] = 9'h1FF;
        rom[10'h021] = 9'h1FF;
        launch(10'h020);
        chk("t3_at", 32'(rom_addr), 32'h020);
        step();
        chk("t3_taken", 32'(rom_addr), 32'h01B);
        step();
        tk[10'h020] = 1'b0;
        launch(10'h020);
        step();
        chk("t3_not_taken", 32'(rom_addr), 32'h021);
        step();

        // wrap forwards and backwards
        rom[10'h000] = 9'h1FF;
        launch(10'h3FF);
        step();
        chk("t4_wrap_fwd", 32'(rom_addr), 32'h000);
        step();
        br[10'h002]  = 1'b1;
        tk[10'h002]  = 1'b1;
        off[10'h002] = 8'hFC;
        rom[10'h3FE] = 9'h1FF;
        launch(10'h002);
        step();
        chk("t4_wrap_back", 32'(rom_addr), 32'h3FE);
        step();
        chk("t4_done", 32'(done), 32'h1);

        // halt wins over a taken branch
        rom[10'h030] = 9'h1FF;
        br[10'h030]  = 1'b1;
        tk[10'h030]  = 1'b1;
        off[10'h030] = 8'h10;
        launch(10'h030);
        chk("t5_valid", 32'(instr_valid), 32'h1);
        step();
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_pc_held", 32'(rom_addr), 32'h030);
        chk("t5_cycles", 32'(cycles), 32'd1);
        step();
        chk("t5_frozen", 32'(rom_addr), 32'h030);

        // restart mid-run, reset during run, relaunch from DONE
        launch(10'h050);
        repeat (5) step();
        chk("t6_at55", 32'(rom_addr), 32'h055);
        launch(10'h100);
        chk("t6_restart_pc", 32'(rom_addr), 32'h100);
        chk("t6_restart_cyc", 32'(cycles), 32'd0);
        step();
        chk("t6_next", 32'(rom_addr), 32'h101);
        rst_n = 1'b0;
        step();
        chk("t6_rst_valid", 32'(instr_valid), 32'h0);
        chk("t6_rst_addr", 32'(rom_addr), 32'h0);
        chk("t6_rst_cycles", 32'(cycles), 32'h0);
        rst_n = 1'b1;
        rom[10'h102] = 9'h1FF;
        launch(10'h100);
        step();
        step();
        step();
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_done_cyc", 32'(cycles), 32'd3);
        launch(10'h200);
        chk("t6_done_fall", 32'(done), 32'h0);
        chk("t6_relaunch", 32'(rom_addr), 32'h200);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
